vec_mul_sequencer: RTL

Control FSM for the 64-lane vector-multiply datapath. One `start` pulse makes it:
- pop one weight tile from the weight FIFO;
- pulse `weight_reload` into the PE array;
- stream N consecutive unified-buffer addresses into the array;
- raise `valid_address` and a result index, aligned to the array's output latency, so the results SRAM captures each output vector.

It sits beside the existing state-machine/counter logic in the top level and replaces the external hand-driven FIFO, address and valid strobes.

---
 rtl/vec_mul_sequencer_pkg.sv | 20 ++
 rtl/vec_mul_sequencer_if.sv | 34 +++
 rtl/vec_mul_sequencer_window_counter.sv | 28 ++
 rtl/vec_mul_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vec_mul_sequencer_pkg.sv
// Shared definitions for the vector-multiply control sequencer:
// FSM state encoding and default array geometry.
package vec_mul_sequencer_pkg;

  localparam int ADDRESSSIZE_DEFAULT  = 10;
  // SRAM read latency plus the 64-deep systolic array.
  localparam int PIPE_LATENCY_DEFAULT = 65;
  localparam int CNT_W_DEFAULT        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    LOAD_W = 3'd2,
    RELOAD = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } vs_state_e;

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// Job request, weight FIFO, PE array and results-SRAM strobes of the sequencer.
// master = the sequencer itself, slave = the surrounding datapath/host.
interface vec_mul_sequencer_if
  import vec_mul_sequencer_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEFAULT
);

  logic                   start;
  logic [ADDRESSSIZE-1:0] base_addr;
  logic [ADDRESSSIZE:0]   num_vectors;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic [ADDRESSSIZE-1:0] sram_address;
  logic                   addr_valid;
  logic                   valid_address;
  logic [ADDRESSSIZE-1:0] result_index;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, base_addr, num_vectors, fifo_empty,
    output fifo_read_enable, weight_reload, sram_address, addr_valid,
           valid_address, result_index, busy, done
  );

  modport slave (
    output start, base_addr, num_vectors, fifo_empty,
    input  fifo_read_enable, weight_reload, sram_address, addr_valid,
           valid_address, result_index, busy, done
  );

endinterface

// File: rtl/vec_mul_sequencer_window_counter.sv
// Loadable down-counter with enable and zero flag; used for the issue count,
// the pipeline-latency wait and the result window.
module vs_window_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/vec_mul_sequencer.sv
// Control FSM for the 64-lane vector-multiply datapath: weight pop, reload,
// contiguous address issue and latency-aligned result window.
module vec_mul_sequencer
  import vec_mul_sequencer_pkg::*;
#(
  parameter int ADDRESSSIZE  = ADDRESSSIZE_DEFAULT,
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  vec_mul_sequencer_if.master  bus
);

  localparam int NW = ADDRESSSIZE + 1;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_WAIT_W = WAIT_W;
  localparam logic [2:0] ST_LOAD_W = LOAD_W;
  localparam logic [2:0] ST_RELOAD = RELOAD;
  localparam logic [2:0] ST_STREAM = STREAM;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(PIPE_LATENCY - 1);

  logic [2:0]             state_reg, state_next;
  logic [ADDRESSSIZE-1:0] base_reg;
  logic [NW-1:0]          num_reg;

  logic                   fifo_read_enable_reg;
  logic                   weight_reload_reg;
  logic                   addr_valid_reg;
  logic [ADDRESSSIZE-1:0] sram_address_reg;
  logic                   valid_address_reg;
  logic [ADDRESSSIZE-1:0] result_index_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   lat_run_reg;

  logic issue_load, issue_en, issue_zero;
  logic lat_load, lat_en, lat_zero, lat_fire;
  logic res_load, res_en, res_zero, win_end;
  logic accept;

  assign accept   = (state_reg == ST_IDLE) && bus.start;
  assign lat_fire = lat_run_reg && lat_zero;
  assign lat_en   = lat_run_reg && !lat_zero;
  assign win_end  = valid_address_reg && res_zero;
  assign res_en   = valid_address_reg && !res_zero;
  assign res_load = lat_fire;

  always_comb begin
    state_next = state_reg;
    issue_load = 1'b0;
    issue_en   = 1'b0;
    lat_load   = 1'b0;
    case (state_reg)
      ST_IDLE:   if (bus.start) state_next = ST_WAIT_W;
      ST_WAIT_W: if (!bus.fifo_empty) state_next = ST_LOAD_W;
      ST_LOAD_W: state_next = ST_RELOAD;
      ST_RELOAD: begin
        if (num_reg != '0) begin
          state_next = ST_STREAM;
          issue_load = 1'b1;
          lat_load   = 1'b1;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_STREAM: begin
        if (issue_zero) state_next = ST_DRAIN;
        else            issue_en   = 1'b1;
      end
      // Window always closes after issue ends since latency is at least one.
      ST_DRAIN:  if (win_end) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Counters hold "remaining after the current cycle", so they load N-1 / L-1.
  vs_window_counter #(.W(NW)) u_issue_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load       (issue_load),
    .load_value (num_reg - 1'b1),
    .en         (issue_en),
    .zero       (issue_zero)
  );

  vs_window_counter #(.W(CNT_W)) u_lat_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load       (lat_load),
    .load_value (LAT_LOAD),
    .en         (lat_en),
    .zero       (lat_zero)
  );

  vs_window_counter #(.W(NW)) u_res_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load       (res_load),
    .load_value (num_reg - 1'b1),
    .en         (res_en),
    .zero       (res_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg            <= ST_IDLE;
      base_reg             <= '0;
      num_reg              <= '0;
      fifo_read_enable_reg <= 1'b0;
      weight_reload_reg    <= 1'b0;
      addr_valid_reg       <= 1'b0;
      sram_address_reg     <= '0;
      valid_address_reg    <= 1'b0;
      result_index_reg     <= '0;
      busy_reg             <= 1'b0;
      done_reg             <= 1'b0;
      lat_run_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        base_reg <= bus.base_addr;
        num_reg  <= bus.num_vectors;
      end

      // Strobes are decoded from the next state so they appear with it.
      fifo_read_enable_reg <= (state_next == ST_LOAD_W);
      weight_reload_reg    <= (state_next == ST_RELOAD);
      addr_valid_reg       <= (state_next == ST_STREAM);
      busy_reg             <= (state_next != ST_IDLE);
      done_reg             <= (state_next == ST_DONE);

      if (state_reg == ST_RELOAD) begin
        sram_address_reg <= base_reg;
      end else if (issue_en) begin
        sram_address_reg <= sram_address_reg + 1'b1;
      end

      if (lat_load) begin
        lat_run_reg <= 1'b1;
      end else if (lat_fire) begin
        lat_run_reg <= 1'b0;
      end

      if (lat_fire) begin
        valid_address_reg <= 1'b1;
        result_index_reg  <= '0;
      end else if (win_end) begin
        valid_address_reg <= 1'b0;
      end else if (res_en) begin
        result_index_reg  <= result_index_reg + 1'b1;
      end
    end
  end

  assign bus.fifo_read_enable = fifo_read_enable_reg;
  assign bus.weight_reload    = weight_reload_reg;
  assign bus.sram_address     = sram_address_reg;
  assign bus.addr_valid       = addr_valid_reg;
  assign bus.valid_address    = valid_address_reg;
  assign bus.result_index     = result_index_reg;
  assign bus.busy             = busy_reg;
  assign bus.done             = done_reg;

endmodule
